opendap_sw_dp_regs: RTL and testbench

DP register file and AP access launcher sitting directly downstream of the SW-DP serial comms block. It decodes the parallel DP/AP accesses, holds DPIDR/CTRL-STAT/SELECT/RDBUFF/ABORT state and the sticky flags, and returns read data. It also generates the WAIT/FAULT/protocol-error indications consumed at the park bit, and issues single posted accesses to the AP interconnect.

---
 rtl/opendap_sw_dp_regs.sv | 330 +++++++++++++++++++++++++++++++++
 tb/tb_opendap_sw_dp_regs.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/opendap_sw_dp_regs.sv
// ---------------------------------------------------------------------------
// opendap_sw_dp_regs
//
// DP register file and AP access launcher for a SW-DP. It sits directly
// behind the serial comms block and receives one parallel access per
// bus_en strobe. The block:
//   * decodes DP reads/writes (DPIDR, CTRL/STAT, DLCR, TARGETID, DLPIDR,
//     SELECT, RDBUFF, ABORT, TARGETSEL)
//   * holds the sticky flags WDATAERR / STICKYERR / STICKYORUN and READOK
//   * synchronises the power-up / reset acknowledges into CTRL/STAT
//   * launches single posted accesses to the AP interconnect and captures
//     the AP read result in RDBUFF
//   * drives the combinational WAIT / FAULT / protocol-error qualifiers that
//     the comms block samples at the park bit
//
// Ports
//   swclk, rst_n              debug clock, asynchronous active-low reset
//   bus_addr/r_nw/ap_ndp      access header: A[3:2], direction, AP/DP select
//   bus_wdata, bus_en         write data and one-cycle access strobe
//   bus_rdata                 read data (combinational from header + state)
//   dp_set_wdataerr           set WDATAERR
//   dp_set_stickyorun         set STICKYORUN
//   dp_clear_readok           clear READOK
//   dp_orundetect             CTRL/STAT.ORUNDETECT
//   dp_acc_fault/wait/protocol_err  response qualifiers (combinational)
//   cdbgpwrupreq, csyspwrupreq, cdbgrstreq   request outputs (registered)
//   cdbgpwrupack, csyspwrupack, cdbgrstack   asynchronous acknowledges
//   ap_en                     one-cycle AP access start
//   ap_sel, ap_addr, ap_r_nw, ap_wdata       AP access fields, held per launch
//   ap_abort                  one-cycle DAPABORT pulse
//   ap_done, ap_err, ap_rdata AP completion, error and read data
// ---------------------------------------------------------------------------
module opendap_sw_dp_regs #(
    parameter logic [31:0] DPIDR_VALUE    = 32'h0BC12477,
    parameter logic [31:0] TARGETID_VALUE = 32'h00000001,
    parameter logic [31:0] DLPIDR_VALUE   = 32'h00000001
) (
    input  logic        swclk,
    input  logic        rst_n,

    input  logic [1:0]  bus_addr,
    input  logic        bus_r_nw,
    input  logic        bus_ap_ndp,
    input  logic [31:0] bus_wdata,
    input  logic        bus_en,
    output logic [31:0] bus_rdata,

    input  logic        dp_set_wdataerr,
    input  logic        dp_set_stickyorun,
    input  logic        dp_clear_readok,
    output logic        dp_orundetect,

    output logic        dp_acc_fault,
    output logic        dp_acc_wait,
    output logic        dp_acc_protocol_err,

    output logic        cdbgpwrupreq,
    output logic        csyspwrupreq,
    output logic        cdbgrstreq,
    input  logic        cdbgpwrupack,
    input  logic        csyspwrupack,
    input  logic        cdbgrstack,

    output logic        ap_en,
    output logic [7:0]  ap_sel,
    output logic [7:0]  ap_addr,
    output logic        ap_r_nw,
    output logic [31:0] ap_wdata,
    output logic        ap_abort,
    input  logic        ap_done,
    input  logic        ap_err,
    input  logic [31:0] ap_rdata
);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    // Acknowledge synchronisers, bit order {csyspwrupack, cdbgpwrupack, cdbgrstack}
    logic [2:0]  ack_meta_r;
    logic [2:0]  ack_sync_r;

    // SELECT fields
    logic [7:0]  apsel_r;
    logic [3:0]  apbanksel_r;
    logic [3:0]  dpbanksel_r;

    // CTRL/STAT writable bits
    logic        csyspwrupreq_r;
    logic        cdbgpwrupreq_r;
    logic        cdbgrstreq_r;
    logic        orundetect_r;

    // CTRL/STAT status flags
    logic        wdataerr_r;
    logic        readok_r;
    logic        stickyerr_r;
    logic        stickyorun_r;

    // Read buffer for posted AP reads
    logic [31:0] rdbuff_r;

    // AP launch state
    logic        ap_busy_r;
    logic        ap_en_r;
    logic [7:0]  ap_sel_r;
    logic [7:0]  ap_addr_r;
    logic        ap_r_nw_r;
    logic [31:0] ap_wdata_r;
    logic        ap_abort_r;

    // -----------------------------------------------------------------------
    // Combinational decode
    // -----------------------------------------------------------------------
    logic        hdr_dp_rd_s;
    logic        hdr_dp_wr_s;
    logic        hdr_rdbuff_s;
    logic        sticky_any_s;
    logic        fault_s;
    logic        wait_s;
    logic        perr_s;
    logic        accept_s;
    logic        ap_launch_s;
    logic        wr_abort_s;
    logic        wr_ctrl_s;
    logic        wr_select_s;
    logic        rd_rdbuff_s;
    logic        done_acc_s;
    logic [31:0] ctrl_stat_s;
    logic [31:0] rdata_s;

    // Header decode, response qualifiers and access qualification.
    always_comb begin
        hdr_dp_rd_s  = !bus_ap_ndp && bus_r_nw;
        hdr_dp_wr_s  = !bus_ap_ndp && !bus_r_nw;
        hdr_rdbuff_s = hdr_dp_rd_s && (bus_addr == 2'd3);
        sticky_any_s = stickyerr_r | stickyorun_r | wdataerr_r;

        // FAULT outranks WAIT: a faulted AP header must never see WAIT.
        fault_s      = bus_ap_ndp && sticky_any_s;
        wait_s       = !fault_s && ap_busy_r && (bus_ap_ndp || hdr_rdbuff_s);
        perr_s       = hdr_dp_wr_s && (bus_addr == 2'd1) && (dpbanksel_r >= 4'd2);

        // An access answered with WAIT or FAULT has no side effect here.
        accept_s     = bus_en && !fault_s && !wait_s;
        ap_launch_s  = accept_s && bus_ap_ndp;
        wr_abort_s   = accept_s && hdr_dp_wr_s && (bus_addr == 2'd0);
        wr_ctrl_s    = accept_s && hdr_dp_wr_s && (bus_addr == 2'd1) && (dpbanksel_r == 4'd0);
        wr_select_s  = accept_s && hdr_dp_wr_s && (bus_addr == 2'd2);
        rd_rdbuff_s  = accept_s && hdr_rdbuff_s;

        // Completion counts only for an outstanding access, and never in the
        // same cycle that access is being presented on ap_en.
        done_acc_s   = ap_done && ap_busy_r && !ap_en_r;
    end

    // CTRL/STAT read image.
    always_comb begin
        ctrl_stat_s = {ack_sync_r[2], csyspwrupreq_r,
                       ack_sync_r[1], cdbgpwrupreq_r,
                       ack_sync_r[0], cdbgrstreq_r,
                       18'h00000,
                       wdataerr_r, readok_r, stickyerr_r,
                       3'b000,
                       stickyorun_r, orundetect_r};
    end

    // Read data mux: AP reads return the previous result held in RDBUFF.
    always_comb begin
        rdata_s = 32'h00000000;
        if (bus_ap_ndp) begin
            if (bus_r_nw) begin
                rdata_s = rdbuff_r;
            end else begin
                rdata_s = 32'h00000000;
            end
        end else if (bus_r_nw) begin
            case (bus_addr)
                2'd0: rdata_s = DPIDR_VALUE;
                2'd1: begin
                    case (dpbanksel_r)
                        4'd0:    rdata_s = ctrl_stat_s;
                        4'd1:    rdata_s = 32'h00000000;
                        4'd2:    rdata_s = TARGETID_VALUE;
                        4'd3:    rdata_s = DLPIDR_VALUE;
                        default: rdata_s = 32'h00000000;
                    endcase
                end
                2'd2:    rdata_s = 32'h00000000;
                2'd3:    rdata_s = rdbuff_r;
                default: rdata_s = 32'h00000000;
            endcase
        end else begin
            rdata_s = 32'h00000000;
        end
    end

    // -----------------------------------------------------------------------
    // Sequential state
    // -----------------------------------------------------------------------

    // Two-flop synchronisers for the asynchronous acknowledges.
    always_ff @(posedge swclk or negedge rst_n) begin
        if (!rst_n) begin
            ack_meta_r <= 3'b000;
            ack_sync_r <= 3'b000;
        end else begin
            ack_meta_r <= {csyspwrupack, cdbgpwrupack, cdbgrstack};
            ack_sync_r <= ack_meta_r;
        end
    end

    // SELECT register.
    always_ff @(posedge swclk or negedge rst_n) begin
        if (!rst_n) begin
            apsel_r     <= 8'h00;
            apbanksel_r <= 4'h0;
            dpbanksel_r <= 4'h0;
        end else if (wr_select_s) begin
            apsel_r     <= bus_wdata[31:24];
            apbanksel_r <= bus_wdata[7:4];
            dpbanksel_r <= bus_wdata[3:0];
        end
    end

    // CTRL/STAT writable bits: power/reset requests and ORUNDETECT.
    always_ff @(posedge swclk or negedge rst_n) begin
        if (!rst_n) begin
            csyspwrupreq_r <= 1'b0;
            cdbgpwrupreq_r <= 1'b0;
            cdbgrstreq_r   <= 1'b0;
            orundetect_r   <= 1'b0;
        end else if (wr_ctrl_s) begin
            csyspwrupreq_r <= bus_wdata[30];
            cdbgpwrupreq_r <= bus_wdata[28];
            cdbgrstreq_r   <= bus_wdata[26];
            orundetect_r   <= bus_wdata[0];
        end
    end

    // Sticky flags and READOK; a set event wins over an ABORT clear.
    always_ff @(posedge swclk or negedge rst_n) begin
        if (!rst_n) begin
            wdataerr_r   <= 1'b0;
            stickyorun_r <= 1'b0;
            stickyerr_r  <= 1'b0;
            readok_r     <= 1'b0;
        end else begin
            if (dp_set_wdataerr) begin
                wdataerr_r <= 1'b1;
            end else if (wr_abort_s && bus_wdata[3]) begin
                wdataerr_r <= 1'b0;
            end

            if (dp_set_stickyorun) begin
                stickyorun_r <= 1'b1;
            end else if (wr_abort_s && bus_wdata[4]) begin
                stickyorun_r <= 1'b0;
            end

            if (done_acc_s && ap_err) begin
                stickyerr_r <= 1'b1;
            end else if (wr_abort_s && bus_wdata[2]) begin
                stickyerr_r <= 1'b0;
            end

            if ((done_acc_s && !ap_err && ap_r_nw_r) || rd_rdbuff_s) begin
                readok_r <= 1'b1;
            end else if (dp_clear_readok) begin
                readok_r <= 1'b0;
            end
        end
    end

    // RDBUFF captures the result of each completed AP read.
    always_ff @(posedge swclk or negedge rst_n) begin
        if (!rst_n) begin
            rdbuff_r <= 32'h00000000;
        end else if (done_acc_s && ap_r_nw_r) begin
            rdbuff_r <= ap_rdata;
        end
    end

    // AP launch: strobe, busy tracking, held access fields and DAPABORT.
    always_ff @(posedge swclk or negedge rst_n) begin
        if (!rst_n) begin
            ap_busy_r  <= 1'b0;
            ap_en_r    <= 1'b0;
            ap_sel_r   <= 8'h00;
            ap_addr_r  <= 8'h00;
            ap_r_nw_r  <= 1'b0;
            ap_wdata_r <= 32'h00000000;
            ap_abort_r <= 1'b0;
        end else begin
            ap_en_r    <= ap_launch_s;
            ap_abort_r <= wr_abort_s && bus_wdata[0];

            if (ap_launch_s) begin
                ap_busy_r <= 1'b1;
            end else if (done_acc_s || (wr_abort_s && bus_wdata[0])) begin
                ap_busy_r <= 1'b0;
            end

            if (ap_launch_s) begin
                ap_sel_r   <= apsel_r;
                ap_addr_r  <= {apbanksel_r, bus_addr, 2'b00};
                ap_r_nw_r  <= bus_r_nw;
                ap_wdata_r <= bus_wdata;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign bus_rdata           = rdata_s;
    assign dp_acc_fault        = fault_s;
    assign dp_acc_wait         = wait_s;
    assign dp_acc_protocol_err = perr_s;
    assign dp_orundetect       = orundetect_r;
    assign cdbgpwrupreq        = cdbgpwrupreq_r;
    assign csyspwrupreq        = csyspwrupreq_r;
    assign cdbgrstreq          = cdbgrstreq_r;
    assign ap_en               = ap_en_r;
    assign ap_sel              = ap_sel_r;
    assign ap_addr             = ap_addr_r;
    assign ap_r_nw             = ap_r_nw_r;
    assign ap_wdata            = ap_wdata_r;
    assign ap_abort            = ap_abort_r;

endmodule

// File: tb/tb_opendap_sw_dp_regs.sv
// ---------------------------------------------------------------------------
// tb_opendap_sw_dp_regs
//
// Directed bench for opendap_sw_dp_regs. Each access pushes its expected
// response onto acc_q; each expected AP launch pushes onto ap_q. A monitor
// samples on the falling edge: on every bus_en it pops acc_q and checks
// read data and the response qualifiers, one cycle later it checks that
// ap_en / ap_abort pulse as predicted, and on every ap_en it pops ap_q and
// checks the launched fields.
// ---------------------------------------------------------------------------
module tb_opendap_sw_dp_regs;

    logic        swclk;
    logic        rst_n;
    logic [1:0]  bus_addr;
    logic        bus_r_nw;
    logic        bus_ap_ndp;
    logic [31:0] bus_wdata;
    logic        bus_en;
    logic [31:0] bus_rdata;
    logic        dp_set_wdataerr;
    logic        dp_set_stickyorun;
    logic        dp_clear_readok;
    logic        dp_orundetect;
    logic        dp_acc_fault;
    logic        dp_acc_wait;
    logic        dp_acc_protocol_err;
    logic        cdbgpwrupreq;
    logic        csyspwrupreq;
    logic        cdbgrstreq;
    logic        cdbgpwrupack;
    logic        csyspwrupack;
    logic        cdbgrstack;
    logic        ap_en;
    logic [7:0]  ap_sel;
    logic [7:0]  ap_addr;
    logic        ap_r_nw;
    logic [31:0] ap_wdata;
    logic        ap_abort;
    logic        ap_done;
    logic        ap_err;
    logic [31:0] ap_rdata;

    opendap_sw_dp_regs dut (
        .swclk               (swclk),
        .rst_n               (rst_n),
        .bus_addr            (bus_addr),
        .bus_r_nw            (bus_r_nw),
        .bus_ap_ndp          (bus_ap_ndp),
        .bus_wdata           (bus_wdata),
        .bus_en              (bus_en),
        .bus_rdata           (bus_rdata),
        .dp_set_wdataerr     (dp_set_wdataerr),
        .dp_set_stickyorun   (dp_set_stickyorun),
        .dp_clear_readok     (dp_clear_readok),
        .dp_orundetect       (dp_orundetect),
        .dp_acc_fault        (dp_acc_fault),
        .dp_acc_wait         (dp_acc_wait),
        .dp_acc_protocol_err (dp_acc_protocol_err),
        .cdbgpwrupreq        (cdbgpwrupreq),
        .csyspwrupreq        (csyspwrupreq),
        .cdbgrstreq          (cdbgrstreq),
        .cdbgpwrupack        (cdbgpwrupack),
        .csyspwrupack        (csyspwrupack),
        .cdbgrstack          (cdbgrstack),
        .ap_en               (ap_en),
        .ap_sel              (ap_sel),
        .ap_addr             (ap_addr),
        .ap_r_nw             (ap_r_nw),
        .ap_wdata            (ap_wdata),
        .ap_abort            (ap_abort),
        .ap_done             (ap_done),
        .ap_err              (ap_err),
        .ap_rdata            (ap_rdata)
    );

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic        chk_rd;
        logic        wt;
        logic        flt;
        logic        perr;
        logic        launch;
        logic        abort;
    } acc_t;

    typedef struct {
        string       name;
        logic [7:0]  sel;
        logic [7:0]  addr;
        logic        rnw;
        logic [31:0] wdata;
    } ap_t;

    acc_t acc_q[$];
    ap_t  ap_q[$];

    int checks   = 0;
    int failures = 0;

    // Clock generation.
    initial begin
        swclk = 1'b0;
        forever #5 swclk = ~swclk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Drive one access for one cycle; called just after a rising edge.
    task automatic acc(input string name, input logic ap, input logic rnw, input logic [1:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_rd, input logic chk_rd,
                       input logic wt, input logic flt, input logic perr,
                       input logic launch, input logic abort);
        acc_t e;
        e.name = name; e.rdata = exp_rd; e.chk_rd = chk_rd; e.wt = wt; e.flt = flt;
        e.perr = perr; e.launch = launch; e.abort = abort;
        acc_q.push_back(e);
        bus_en     = 1'b1;
        bus_ap_ndp = ap;
        bus_r_nw   = rnw;
        bus_addr   = addr;
        bus_wdata  = wdata;
        @(posedge swclk); #1;
        bus_en     = 1'b0;
        bus_wdata  = 32'h00000000;
    endtask

    task automatic dp_rd(input string name, input logic [1:0] addr, input logic [31:0] exp_rd,
                         input logic wt);
        acc(name, 1'b0, 1'b1, addr, 32'h00000000, exp_rd, 1'b1, wt, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic dp_wr(input string name, input logic [1:0] addr, input logic [31:0] data,
                         input logic perr, input logic abort);
        acc(name, 1'b0, 1'b0, addr, data, 32'h00000000, 1'b0, 1'b0, 1'b0, perr, 1'b0, abort);
    endtask

    task automatic ap_acc(input string name, input logic rnw, input logic [1:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rd,
                          input logic wt, input logic flt, input logic launch,
                          input logic [7:0] exp_sel, input logic [7:0] exp_aaddr);
        ap_t a;
        if (launch) begin
            a.name = name; a.sel = exp_sel; a.addr = exp_aaddr; a.rnw = rnw; a.wdata = wdata;
            ap_q.push_back(a);
        end
        acc(name, 1'b1, rnw, addr, wdata, exp_rd, rnw, wt, flt, 1'b0, launch, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge swclk); #1;
        end
    endtask

    task automatic ap_complete(input logic err, input logic [31:0] data);
        ap_done  = 1'b1;
        ap_err   = err;
        ap_rdata = data;
        @(posedge swclk); #1;
        ap_done  = 1'b0;
        ap_err   = 1'b0;
        ap_rdata = 32'h00000000;
    endtask

    // Monitor: compares DUT responses against the queued expectations.
    initial begin : monitor
        acc_t e;
        ap_t  a;
        logic pend_launch;
        logic pend_abort;
        pend_launch = 1'b0;
        pend_abort  = 1'b0;
        forever begin
            @(negedge swclk);
            if (pend_launch || ap_en) begin
                check("ap_en_timing", {63'd0, ap_en}, {63'd0, pend_launch});
            end
            if (ap_en) begin
                if (ap_q.size() == 0) begin
                    check("ap_unexpected_launch", 64'd1, 64'd0);
                end else begin
                    a = ap_q.pop_front();
                    check({"ap_fields_", a.name}, {15'd0, ap_sel, ap_addr, ap_r_nw, ap_wdata},
                          {15'd0, a.sel, a.addr, a.rnw, a.wdata});
                end
            end
            if (pend_abort || ap_abort) begin
                check("ap_abort_timing", {63'd0, ap_abort}, {63'd0, pend_abort});
            end
            pend_launch = 1'b0;
            pend_abort  = 1'b0;
            if (bus_en) begin
                if (acc_q.size() == 0) begin
                    check("acc_unexpected", 64'd1, 64'd0);
                end else begin
                    e = acc_q.pop_front();
                    check(e.name,
                          {29'd0, (e.chk_rd ? bus_rdata : 32'h00000000),
                           dp_acc_wait, dp_acc_fault, dp_acc_protocol_err},
                          {29'd0, (e.chk_rd ? e.rdata : 32'h00000000), e.wt, e.flt, e.perr});
                    pend_launch = e.launch;
                    pend_abort  = e.abort;
                end
            end
        end
    end

    // Watchdog so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    // Directed stimulus.
    initial begin
        rst_n = 1'b0;
        bus_addr = 2'd0; bus_r_nw = 1'b0; bus_ap_ndp = 1'b0; bus_wdata = 32'h00000000;
        bus_en = 1'b0;
        dp_set_wdataerr = 1'b0; dp_set_stickyorun = 1'b0; dp_clear_readok = 1'b0;
        cdbgpwrupack = 1'b0; csyspwrupack = 1'b0; cdbgrstack = 1'b0;
        ap_done = 1'b0; ap_err = 1'b0; ap_rdata = 32'h00000000;

        repeat (3) @(posedge swclk);
        #1;
        check("reset_outputs",
              {10'd0, ap_en, ap_abort, cdbgpwrupreq, csyspwrupreq, cdbgrstreq, dp_orundetect,
               ap_sel, ap_addr, ap_r_nw, ap_wdata},
              64'd0);
        rst_n = 1'b1;
        idle(1);

        // Identification and reset CTRL/STAT.
        dp_rd("dpidr", 2'd0, 32'h0BC12477, 1'b0);
        dp_rd("ctrlstat_reset", 2'd1, 32'h00000000, 1'b0);

        // Power-up requests and synchronised acks.
        dp_wr("ctrlstat_wr", 2'd1, 32'h50000000, 1'b0, 1'b0);
        check("pwrup_reqs", {61'd0, cdbgpwrupreq, csyspwrupreq, cdbgrstreq}, {61'd0, 3'b110});
        cdbgpwrupack = 1'b1;
        csyspwrupack = 1'b1;
        idle(3);
        dp_rd("ctrlstat_acks", 2'd1, 32'hF0000000, 1'b0);

        // Posted AP read through SELECT.
        dp_wr("select_wr", 2'd2, 32'h050000F0, 1'b0, 1'b0);
        ap_acc("ap_rd1", 1'b1, 2'd1, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b1, 8'h05, 8'hF4);
        ap_acc("ap_wait", 1'b1, 2'd2, 32'h00000000, 32'h00000000, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        dp_rd("rdbuff_wait", 2'd3, 32'h00000000, 1'b1);
        ap_complete(1'b0, 32'hCAFEF00D);
        dp_rd("rdbuff_data", 2'd3, 32'hCAFEF00D, 1'b0);
        dp_rd("ctrlstat_readok", 2'd1, 32'hF0000040, 1'b0);
        dp_clear_readok = 1'b1;
        idle(1);
        dp_clear_readok = 1'b0;
        dp_rd("ctrlstat_readok_clr", 2'd1, 32'hF0000000, 1'b0);

        // AP write that errors -> STICKYERR and FAULT.
        ap_acc("ap_wr0", 1'b0, 2'd0, 32'h12345678, 32'h00000000, 1'b0, 1'b0, 1'b1, 8'h05, 8'hF0);
        idle(1);
        ap_complete(1'b1, 32'hDEADBEEF);
        ap_acc("ap_fault_stickyerr", 1'b1, 2'd0, 32'h00000000, 32'hCAFEF00D,
               1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
        dp_rd("ctrlstat_stickyerr", 2'd1, 32'hF0000020, 1'b0);
        dp_wr("abort_stkerr", 2'd0, 32'h00000004, 1'b0, 1'b0);

        // Fault cleared; launch then DAPABORT while busy.
        ap_acc("ap_rd0_after_clr", 1'b1, 2'd0, 32'h00000000, 32'hCAFEF00D,
               1'b0, 1'b0, 1'b1, 8'h05, 8'hF0);
        dp_wr("abort_dap", 2'd0, 32'h00000001, 1'b0, 1'b1);
        ap_acc("ap_rd3_after_abort", 1'b1, 2'd3, 32'h00000000, 32'hCAFEF00D,
               1'b0, 1'b0, 1'b1, 8'h05, 8'hFC);
        idle(1);
        ap_complete(1'b0, 32'hA5A5A5A5);
        ap_complete(1'b1, 32'h00000000);
        dp_rd("ctrlstat_idle_done", 2'd1, 32'hF0000040, 1'b0);
        dp_rd("rdbuff_a5", 2'd3, 32'hA5A5A5A5, 1'b0);

        // WDATAERR set wins over clear in the same cycle.
        dp_set_wdataerr = 1'b1;
        dp_wr("abort_wderr_race", 2'd0, 32'h00000008, 1'b0, 1'b0);
        dp_set_wdataerr = 1'b0;
        dp_rd("ctrlstat_wdataerr", 2'd1, 32'hF00000C0, 1'b0);
        ap_acc("ap_fault_wdataerr", 1'b1, 2'd0, 32'h00000000, 32'hA5A5A5A5,
               1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
        dp_wr("abort_wderr", 2'd0, 32'h00000008, 1'b0, 1'b0);

        // STICKYORUN set and clear.
        dp_set_stickyorun = 1'b1;
        idle(1);
        dp_set_stickyorun = 1'b0;
        dp_rd("ctrlstat_stickyorun", 2'd1, 32'hF0000042, 1'b0);
        ap_acc("ap_fault_orun", 1'b1, 2'd1, 32'h00000000, 32'hA5A5A5A5,
               1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
        dp_wr("abort_orun", 2'd0, 32'h00000010, 1'b0, 1'b0);
        dp_rd("ctrlstat_clean", 2'd1, 32'hF0000040, 1'b0);

        // ORUNDETECT and DP banking.
        dp_wr("ctrlstat_orund", 2'd1, 32'h50000001, 1'b0, 1'b0);
        check("orundetect_set", {63'd0, dp_orundetect}, 64'd1);
        dp_wr("select_bank2", 2'd2, 32'h00000002, 1'b0, 1'b0);
        dp_wr("bank2_wr_perr", 2'd1, 32'h00000000, 1'b1, 1'b0);
        check("bank2_wr_ignored", {62'd0, dp_orundetect, cdbgpwrupreq}, {62'd0, 2'b11});
        dp_rd("targetid", 2'd1, 32'h00000001, 1'b0);
        dp_wr("select_bank3", 2'd2, 32'h00000003, 1'b0, 1'b0);
        dp_rd("dlpidr", 2'd1, 32'h00000001, 1'b0);
        dp_wr("select_bank1", 2'd2, 32'h00000001, 1'b0, 1'b0);
        dp_rd("dlcr", 2'd1, 32'h00000000, 1'b0);
        dp_wr("bank1_wr_ok", 2'd1, 32'h00000000, 1'b0, 1'b0);
        dp_wr("select_bank5", 2'd2, 32'h00000005, 1'b0, 1'b0);
        dp_rd("bank5_zero", 2'd1, 32'h00000000, 1'b0);
        dp_rd("dpidr_final", 2'd0, 32'h0BC12477, 1'b0);

        idle(3);
        check("acc_q_drained", 64'(acc_q.size()), 64'd0);
        check("ap_q_drained", 64'(ap_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
